// File: rtl/rename_regfile_mp_if.sv
// Bus bundle between the issue unit / ROB (master) and the rename register file (slave).
// Valid semantics: cm_valid[c] and iss_valid qualify their payload fields in the cycle they are
// high and are consumed on the rising edge when rdy=1; there is no ready return, so the
// master never stalls and rdy=0 simply discards that cycle's requests without any state change.
interface rename_regfile_mp_if #(
    parameter int XLEN     = 32,
    parameter int NREG     = 32,
    parameter int ROB_W    = 6,
    parameter int NREAD    = 4,
    parameter int COMMIT_W = 2
);
    localparam int RW = $clog2(NREG);

    logic                      rdy;
    logic                      flush;
    logic [COMMIT_W-1:0]       cm_valid;
    logic [COMMIT_W*RW-1:0]    cm_rd;
    logic [COMMIT_W*ROB_W-1:0] cm_index;
    logic [COMMIT_W*XLEN-1:0]  cm_value;
    logic                      iss_valid;
    logic [RW-1:0]             iss_rd;
    logic [ROB_W-1:0]          iss_tag;
    logic [NREAD*RW-1:0]       rd_idx;
    logic [NREAD*XLEN-1:0]     rd_val;
    logic [NREAD*ROB_W-1:0]    rd_dep;
    logic [NREAD-1:0]          rd_has_dep;
    logic [RW:0]               pending_cnt;

    modport master (
        output rdy, flush, cm_valid, cm_rd, cm_index, cm_value,
        output iss_valid, iss_rd, iss_tag, rd_idx,
        input  rd_val, rd_dep, rd_has_dep, pending_cnt
    );

    modport slave (
        input  rdy, flush, cm_valid, cm_rd, cm_index, cm_value,
        input  iss_valid, iss_rd, iss_tag, rd_idx,
        output rd_val, rd_dep, rd_has_dep, pending_cnt
    );
endinterface

// File: rtl/rename_regfile_mp.sv
// Architectural register file plus rename table. Multi-port reads with same-cycle commit
// bypass, multi-port in-order commit, single destination rename per cycle, flush clears deps.
module rename_regfile_mp #(
    parameter int XLEN     = 32,
    parameter int NREG     = 32,
    parameter int ROB_W    = 6,
    parameter int NREAD    = 4,
    parameter int COMMIT_W = 2
) (
    input logic               clk,
    input logic               rst_n,
    rename_regfile_mp_if.slave bus
);
    localparam int RW = $clog2(NREG);

    logic [XLEN-1:0]  regs [NREG];
    logic [ROB_W-1:0] tags [NREG];
    logic [NREG-1:0]  busy;
    logic [NREG-1:0]  busy_nxt;
    logic [RW:0]      cnt_q;
    logic [RW:0]      cnt_nxt;

    // Unpacked views of the flattened commit ports.
    logic [RW-1:0]    cm_rd_a  [COMMIT_W];
    logic [ROB_W-1:0] cm_idx_a [COMMIT_W];
    logic [XLEN-1:0]  cm_val_a [COMMIT_W];

    for (genvar c = 0; c < COMMIT_W; c++) begin : g_cm
        assign cm_rd_a[c]  = bus.cm_rd[c*RW +: RW];
        assign cm_idx_a[c] = bus.cm_index[c*ROB_W +: ROB_W];
        assign cm_val_a[c] = bus.cm_value[c*XLEN +: XLEN];
    end

    for (genvar p = 0; p < NREAD; p++) begin : g_rd
        logic [RW-1:0]    r;
        logic             hit;
        logic [XLEN-1:0]  byp;
        logic [XLEN-1:0]  val;
        logic [ROB_W-1:0] dep;
        logic             has_dep;

        assign r = bus.rd_idx[p*RW +: RW];

        // Look for a commit retiring the tag this source is waiting on; younger port wins.
        always_comb begin
            hit = 1'b0;
            byp = '0;
            for (int c = 0; c < COMMIT_W; c++) begin
                if (busy[r] && bus.cm_valid[c] && cm_rd_a[c] == r && cm_idx_a[c] == tags[r]) begin
                    hit = 1'b1;
                    byp = cm_val_a[c];
                end
            end
        end

        // Resolve the source: x0 is constant zero, bypass beats the stored state.
        always_comb begin
            val     = '0;
            dep     = '0;
            has_dep = 1'b0;
            if (r != '0) begin
                if (hit) begin
                    val = byp;
                end else begin
                    val     = regs[r];
                    has_dep = busy[r];
                    dep     = busy[r] ? tags[r] : '0;
                end
            end
        end

        assign bus.rd_val[p*XLEN +: XLEN]   = val;
        assign bus.rd_dep[p*ROB_W +: ROB_W] = dep;
        assign bus.rd_has_dep[p]            = has_dep;
    end

    // Next busy vector: matching commits clear, then flush clears all or issue sets (issue wins).
    always_comb begin
        busy_nxt = busy;
        for (int c = 0; c < COMMIT_W; c++) begin
            if (bus.cm_valid[c] && cm_rd_a[c] != '0 && busy[cm_rd_a[c]] &&
                cm_idx_a[c] == tags[cm_rd_a[c]]) begin
                busy_nxt[cm_rd_a[c]] = 1'b0;
            end
        end
        if (bus.flush) begin
            busy_nxt = '0;
        end else if (bus.iss_valid && bus.iss_rd != '0) begin
            busy_nxt[bus.iss_rd] = 1'b1;
        end
        cnt_nxt = '0;
        for (int i = 0; i < NREG; i++) begin
            cnt_nxt = cnt_nxt + (RW+1)'(busy_nxt[i]);
        end
    end

    // State update: commits write values (younger port last so it wins), issue retags, rdy gates all.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
                tags[i] <= '0;
            end
            busy  <= '0;
            cnt_q <= '0;
        end else if (bus.rdy) begin
            for (int c = 0; c < COMMIT_W; c++) begin
                if (bus.cm_valid[c] && cm_rd_a[c] != '0) begin
                    regs[cm_rd_a[c]] <= cm_val_a[c];
                end
            end
            if (!bus.flush && bus.iss_valid && bus.iss_rd != '0) begin
                tags[bus.iss_rd] <= bus.iss_tag;
            end
            busy  <= busy_nxt;
            cnt_q <= cnt_nxt;
        end
    end

    assign bus.pending_cnt = cnt_q;
endmodule

// File: tb/tb_rename_regfile_mp.sv
// Self-checking bench for rename_regfile_mp: directed vector table, reset corner sequences,
// then randomized traffic against a behavioural model of the register file.
module tb_rename_regfile_mp;
    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int ROB_W = 6;
    localparam int NREAD = 4;
    localparam int COMMIT_W = 2;
    localparam int EW = 1 + ROB_W + XLEN;

    logic clk;
    logic rst_n;
    int checks = 0;
    int failures = 0;

    rename_regfile_mp_if #(.XLEN(XLEN), .NREG(NREG), .ROB_W(ROB_W), .NREAD(NREAD),
                           .COMMIT_W(COMMIT_W)) bus ();

    rename_regfile_mp #(.XLEN(XLEN), .NREG(NREG), .ROB_W(ROB_W), .NREAD(NREAD),
                        .COMMIT_W(COMMIT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    // ---------------- vector table ----------------
    typedef struct {
        string       name;
        logic        rdy, flush, iv;
        logic [4:0]  ird;
        logic [5:0]  itag;
        logic        cv0, cv1;
        logic [4:0]  crd0, crd1;
        logic [5:0]  cix0, cix1;
        logic [31:0] cval0, cval1;
        logic [4:0]  ridx;
        logic [31:0] e_val;
        logic        e_hd;
        logic [5:0]  e_dep;
        logic [5:0]  e_cnt;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(string name, logic rdy, logic flush, logic iv, logic [4:0] ird,
                                logic [5:0] itag, logic cv0, logic [4:0] crd0, logic [5:0] cix0,
                                logic [31:0] cval0, logic cv1, logic [4:0] crd1, logic [5:0] cix1,
                                logic [31:0] cval1, logic [4:0] ridx, logic [31:0] e_val,
                                logic e_hd, logic [5:0] e_dep, logic [5:0] e_cnt);
        vec_t v;
        v.name = name; v.rdy = rdy; v.flush = flush; v.iv = iv; v.ird = ird; v.itag = itag;
        v.cv0 = cv0; v.crd0 = crd0; v.cix0 = cix0; v.cval0 = cval0;
        v.cv1 = cv1; v.crd1 = crd1; v.cix1 = cix1; v.cval1 = cval1;
        v.ridx = ridx; v.e_val = e_val; v.e_hd = e_hd; v.e_dep = e_dep; v.e_cnt = e_cnt;
        return v;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic drive_idle();
        bus.rdy = 1'b1; bus.flush = 1'b0;
        bus.cm_valid = '0; bus.cm_rd = '0; bus.cm_index = '0; bus.cm_value = '0;
        bus.iss_valid = 1'b0; bus.iss_rd = '0; bus.iss_tag = '0; bus.rd_idx = '0;
    endtask

    task automatic drive_vec(input vec_t v);
        bus.rdy = v.rdy; bus.flush = v.flush;
        bus.iss_valid = v.iv; bus.iss_rd = v.ird; bus.iss_tag = v.itag;
        bus.cm_valid = {v.cv1, v.cv0};
        bus.cm_rd = {v.crd1, v.crd0};
        bus.cm_index = {v.cix1, v.cix0};
        bus.cm_value = {v.cval1, v.cval0};
        bus.rd_idx = {NREAD{v.ridx}};
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic chk_port(input string name, input int p, input logic [31:0] e_val,
                            input logic e_hd, input logic [5:0] e_dep);
        chk($sformatf("%s.p%0d.val", name, p), 64'(bus.rd_val[p*XLEN +: XLEN]), 64'(e_val));
        chk($sformatf("%s.p%0d.has_dep", name, p), 64'(bus.rd_has_dep[p]), 64'(e_hd));
        chk($sformatf("%s.p%0d.dep", name, p), 64'(bus.rd_dep[p*ROB_W +: ROB_W]), 64'(e_dep));
    endtask

    // ---------------- behavioural model + scoreboard ----------------
    logic [31:0] m_reg [NREG];
    logic [5:0]  m_tag [NREG];
    bit          m_busy [NREG];
    logic [EW-1:0] exp_q[$];

    task automatic model_reset();
        for (int i = 0; i < NREG; i++) begin
            m_reg[i] = '0; m_tag[i] = '0; m_busy[i] = 0;
        end
    endtask

    function automatic int model_pending();
        int n = 0;
        for (int i = 0; i < NREG; i++) n += int'(m_busy[i]);
        return n;
    endfunction

    // Expected {has_dep, dep, val} for a source register given this cycle's commit inputs.
    function automatic logic [EW-1:0] model_read(input int r);
        logic [31:0] v;
        if (r == 0) return '0;
        if (m_busy[r]) begin
            int hit = -1;
            for (int c = 0; c < COMMIT_W; c++)
                if (bus.cm_valid[c] && int'(bus.cm_rd[c*5 +: 5]) == r &&
                    bus.cm_index[c*6 +: 6] == m_tag[r]) hit = c;
            if (hit >= 0) begin
                v = bus.cm_value[hit*32 +: 32];
                return {1'b0, 6'd0, v};
            end
            return {1'b1, m_tag[r], m_reg[r]};
        end
        return {1'b0, 6'd0, m_reg[r]};
    endfunction

    // Architectural effect of one clock edge with the current inputs.
    task automatic model_step();
        bit clr [NREG];
        if (!bus.rdy) return;
        for (int i = 0; i < NREG; i++) clr[i] = 0;
        for (int c = 0; c < COMMIT_W; c++) begin
            int rd = int'(bus.cm_rd[c*5 +: 5]);
            if (bus.cm_valid[c] && rd != 0) begin
                if (m_busy[rd] && bus.cm_index[c*6 +: 6] == m_tag[rd]) clr[rd] = 1;
                m_reg[rd] = bus.cm_value[c*32 +: 32];
            end
        end
        for (int i = 0; i < NREG; i++) if (clr[i]) m_busy[i] = 0;
        if (bus.flush) begin
            for (int i = 0; i < NREG; i++) m_busy[i] = 0;
        end else if (bus.iss_valid && bus.iss_rd != 0) begin
            m_busy[bus.iss_rd] = 1;
            m_tag[bus.iss_rd] = bus.iss_tag;
        end
    endtask

    // ---------------- test sequence ----------------
    initial begin
        logic [EW-1:0] e;
        drive_idle();
        rst_n = 1'b0;
        bus.rd_idx = {NREAD{5'd5}};
        repeat (2) @(posedge clk);
        #2;
        for (int p = 0; p < NREAD; p++) chk_port("reset_x5", p, 32'h0, 1'b0, 6'd0);
        chk("reset_cnt", 64'(bus.pending_cnt), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        //            name       rdy fl iv ird itag cv0 crd0 cix0 cval0      cv1 crd1 cix1 cval1 ridx e_val       hd dep cnt
        vq.push_back(mk("t1_x5",   1, 0, 0, 0, 0,  0, 0, 0, 0,             0, 0, 0, 0,  5, 32'h0,      0, 0,  0));
        vq.push_back(mk("t2_iss",  1, 0, 1, 3, 7,  0, 0, 0, 0,             0, 0, 0, 0,  3, 32'h0,      0, 0,  0));
        vq.push_back(mk("t2_dep",  1, 0, 0, 0, 0,  0, 0, 0, 0,             0, 0, 0, 0,  3, 32'h0,      1, 7,  1));
        vq.push_back(mk("t2_byp",  1, 0, 0, 0, 0,  1, 3, 7, 32'hDEAD,      0, 0, 0, 0,  3, 32'hDEAD,   0, 0,  1));
        vq.push_back(mk("t2_clr",  1, 0, 0, 0, 0,  0, 0, 0, 0,             0, 0, 0, 0,  3, 32'hDEAD,   0, 0,  0));
        vq.push_back(mk("t3_iss",  1, 0, 1, 3, 7,  0, 0, 0, 0,             0, 0, 0, 0,  3, 32'hDEAD,   0, 0,  0));
        vq.push_back(mk("t3_both", 1, 0, 1, 3, 9,  0, 0, 0, 0,             1, 3, 7, 32'h1234, 3, 32'h1234, 0, 0, 1));
        vq.push_back(mk("t3_chk",  1, 0, 0, 0, 0,  0, 0, 0, 0,             0, 0, 0, 0,  3, 32'h1234,   1, 9,  1));
        vq.push_back(mk("t4_i10",  1, 0, 1, 4, 10, 0, 0, 0, 0,             0, 0, 0, 0,  4, 32'h0,      0, 0,  1));
        vq.push_back(mk("t4_i12",  1, 0, 1, 4, 12, 0, 0, 0, 0,             0, 0, 0, 0,  4, 32'h0,      1, 10, 2));
        vq.push_back(mk("t4_stale",1, 0, 0, 0, 0,  1, 4, 10, 32'h5,        0, 0, 0, 0,  4, 32'h0,      1, 12, 2));
        vq.push_back(mk("t4_chk",  1, 0, 0, 0, 0,  0, 0, 0, 0,             0, 0, 0, 0,  4, 32'h5,      1, 12, 2));
        vq.push_back(mk("t5_dual", 1, 0, 0, 0, 0,  1, 6, 0, 32'h1,         1, 6, 0, 32'h2, 6, 32'h0,   0, 0,  2));
        vq.push_back(mk("t5_x6",   1, 0, 0, 0, 0,  0, 0, 0, 0,             0, 0, 0, 0,  6, 32'h2,      0, 0,  2));
        vq.push_back(mk("t5_x0",   1, 0, 1, 0, 5,  1, 0, 5, 32'hFFFF,      0, 0, 0, 0,  0, 32'h0,      0, 0,  2));
        vq.push_back(mk("t5_x0b",  1, 0, 0, 0, 0,  0, 0, 0, 0,             0, 0, 0, 0,  0, 32'h0,      0, 0,  2));
        vq.push_back(mk("t6_i1",   1, 0, 1, 1, 1,  0, 0, 0, 0,             0, 0, 0, 0,  1, 32'h0,      0, 0,  2));
        vq.push_back(mk("t6_i2",   1, 0, 1, 2, 2,  0, 0, 0, 0,             0, 0, 0, 0,  1, 32'h0,      1, 1,  3));
        vq.push_back(mk("t6_i8",   1, 0, 1, 8, 8,  0, 0, 0, 0,             0, 0, 0, 0,  2, 32'h0,      1, 2,  4));
        vq.push_back(mk("t6_flush",1, 1, 1, 9, 20, 1, 8, 8, 32'h55,        0, 0, 0, 0,  8, 32'h55,     0, 0,  5));
        vq.push_back(mk("t6_x8",   1, 0, 0, 0, 0,  0, 0, 0, 0,             0, 0, 0, 0,  8, 32'h55,     0, 0,  0));
        vq.push_back(mk("t6_x9",   1, 0, 0, 0, 0,  0, 0, 0, 0,             0, 0, 0, 0,  9, 32'h0,      0, 0,  0));
        vq.push_back(mk("t6_x1",   1, 0, 0, 0, 0,  0, 0, 0, 0,             0, 0, 0, 0,  1, 32'h0,      0, 0,  0));
        vq.push_back(mk("t7_hold", 0, 0, 1, 10, 3, 1, 11, 0, 32'h77,       0, 0, 0, 0,  10, 32'h0,     0, 0,  0));
        vq.push_back(mk("t7_x10",  1, 0, 0, 0, 0,  0, 0, 0, 0,             0, 0, 0, 0,  10, 32'h0,     0, 0,  0));
        vq.push_back(mk("t7_x11",  1, 0, 0, 0, 0,  0, 0, 0, 0,             0, 0, 0, 0,  11, 32'h0,     0, 0,  0));
        vq.push_back(mk("t8_i12",  1, 0, 1, 12, 4, 0, 0, 0, 0,             0, 0, 0, 0,  12, 32'h0,     0, 0,  0));
        vq.push_back(mk("t8_hold", 0, 0, 0, 0, 0,  1, 12, 4, 32'h9,        0, 0, 0, 0,  12, 32'h9,     0, 0,  1));
        vq.push_back(mk("t8_chk",  1, 0, 0, 0, 0,  0, 0, 0, 0,             0, 0, 0, 0,  12, 32'h0,     1, 4,  1));

        foreach (vq[i]) begin
            @(negedge clk);
            drive_vec(vq[i]);
            #2;
            for (int p = 0; p < NREAD; p++) chk_port(vq[i].name, p, vq[i].e_val, vq[i].e_hd, vq[i].e_dep);
            chk({vq[i].name, ".cnt"}, 64'(bus.pending_cnt), 64'(vq[i].e_cnt));
        end

        // Asynchronous reset in mid-cycle while an issue is presented.
        @(negedge clk);
        drive_idle();
        bus.iss_valid = 1'b1; bus.iss_rd = 5'd13; bus.iss_tag = 6'd1;
        bus.rd_idx = {5'd0, 5'd13, 5'd8, 5'd12};
        #2;
        rst_n = 1'b0;
        #1;
        chk_port("mrst_x12", 0, 32'h0, 1'b0, 6'd0);
        chk_port("mrst_x8", 1, 32'h0, 1'b0, 6'd0);
        chk("mrst_cnt", 64'(bus.pending_cnt), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        bus.iss_valid = 1'b0;
        #2;
        chk_port("mrst_x13", 2, 32'h0, 1'b0, 6'd0);
        chk("mrst_cnt2", 64'(bus.pending_cnt), 64'd0);

        // Randomized traffic against the model.
        model_reset();
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge clk);
            bus.rdy = ($urandom_range(0, 9) != 0);
            bus.flush = ($urandom_range(0, 19) == 0);
            bus.iss_valid = $urandom_range(0, 1);
            bus.iss_rd = 5'($urandom_range(0, 7));
            bus.iss_tag = 6'($urandom_range(0, 63));
            for (int c = 0; c < COMMIT_W; c++) begin
                int rd = $urandom_range(0, 7);
                logic [5:0] ix = 6'($urandom_range(0, 63));
                if (m_busy[rd] && $urandom_range(0, 1) == 1) ix = m_tag[rd];
                if (c == 1 && rd == int'(bus.cm_rd[4:0]) && ix == bus.cm_index[5:0]) ix = ix ^ 6'd1;
                bus.cm_valid[c] = ($urandom_range(0, 9) < 6);
                bus.cm_rd[c*5 +: 5] = 5'(rd);
                bus.cm_index[c*6 +: 6] = ix;
                bus.cm_value[c*32 +: 32] = $urandom;
            end
            for (int p = 0; p < NREAD; p++) bus.rd_idx[p*5 +: 5] = 5'($urandom_range(0, 8));
            for (int p = 0; p < NREAD; p++) exp_q.push_back(model_read(int'(bus.rd_idx[p*5 +: 5])));
            #2;
            for (int p = 0; p < NREAD; p++) begin
                e = exp_q.pop_front();
                chk_port($sformatf("rnd%0d", cyc), p, e[31:0], e[EW-1], e[EW-2:32]);
            end
            chk($sformatf("rnd%0d.cnt", cyc), 64'(bus.pending_cnt), 64'(model_pending()));
            model_step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
